// File: rtl/polygon_edge_sequencer_if.sv
// polygon_edge_sequencer_if
//   Edge bus between the polygon edge sequencer and the line rasteriser.
//   master (sequencer): drives x0/y0/x1/y1 endpoints and draw_en, receives draw_done.
//   slave  (line engine): receives the edge and draw_en, returns draw_done.
interface polygon_edge_sequencer_if #(
    parameter int COORD_W = 8
);
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic               draw_en;
    logic               draw_done;

    modport master (output x0, y0, x1, y1, draw_en, input draw_done);
    modport slave  (input x0, y0, x1, y1, draw_en, output draw_done);
endinterface

// File: rtl/polygon_edge_sequencer.sv
// polygon_edge_sequencer
//   Feeds the line rasteriser one polygon/polyline edge at a time. The vertex
//   list, vertex count and closed flag are captured when a command is accepted,
//   so the decode stage is free to change its outputs while edges are drawn.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        command strobe (only looked at in IDLE)
//   vert_count   number of valid vertices in coords
//   closed       1 = closed polygon, 0 = open polyline
//   coords       packed vertices, vertex i = {y, x} at [2*COORD_W*i +: 2*COORD_W]
//   line         edge bus to the line engine (master side)
//   busy         high whenever not IDLE
//   done         one-cycle pulse at command completion
//   err          one-cycle pulse when a command is rejected
//   abort        (PSEQ_ABORT_EN only) stop the command early
//   aborted      (PSEQ_ABORT_EN only) qualifies the done pulse of an aborted command
//
// Build option: define PSEQ_ABORT_EN to add the abort/aborted ports.
module polygon_edge_sequencer #(
    parameter int COORD_W   = 8,
    parameter int MAX_VERTS = 8,
    parameter int VCNT_W    = $clog2(MAX_VERTS + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [VCNT_W-1:0]                vert_count,
    input  logic                             closed,
    input  logic [2*COORD_W*MAX_VERTS-1:0]   coords,
`ifdef PSEQ_ABORT_EN
    input  logic                             abort,
    output logic                             aborted,
`endif
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    polygon_edge_sequencer_if.master         line
);
    localparam int IDX_W = $clog2(MAX_VERTS);
    localparam logic [VCNT_W-1:0] ONE  = VCNT_W'(1);
    localparam logic [VCNT_W-1:0] TWO  = VCNT_W'(2);
    localparam logic [VCNT_W-1:0] THREE = VCNT_W'(3);
    localparam logic [VCNT_W-1:0] MAXV = VCNT_W'(MAX_VERTS);

    typedef enum logic [2:0] {S_IDLE, S_ERR, S_DRAW, S_GAP, S_DONE} state_t;

    state_t                                 state_q, state_d;
    logic [MAX_VERTS-1:0][2*COORD_W-1:0]    verts_q, verts_d;
    logic [VCNT_W-1:0]                      vcnt_q, vcnt_d;
    logic                                   closed_q, closed_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
`ifdef PSEQ_ABORT_EN
    logic                                   aborted_q, aborted_d;
`endif

    logic [VCNT_W-1:0] last_idx;   // E-1
    logic [VCNT_W-1:0] idx_ext;
    logic [IDX_W-1:0]  nxt_idx;    // (k+1) mod vert_count
    logic              is_last;
    logic              abort_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            verts_q  <= '0;
            vcnt_q   <= '0;
            closed_q <= 1'b0;
            idx_q    <= '0;
`ifdef PSEQ_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            verts_q  <= verts_d;
            vcnt_q   <= vcnt_d;
            closed_q <= closed_d;
            idx_q    <= idx_d;
`ifdef PSEQ_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    always_comb begin
        // A closed 2-vertex "polygon" draws its single edge once, not twice.
        if (closed_q && vcnt_q >= THREE) last_idx = vcnt_q - ONE;
        else if (closed_q)               last_idx = '0;
        else                             last_idx = vcnt_q - TWO;
        idx_ext = VCNT_W'(idx_q);
        is_last = (idx_ext == last_idx);
        // Closing edge wraps to vertex 0 at the latched count, never past it.
        nxt_idx = (idx_ext == vcnt_q - ONE) ? '0 : idx_q + 1'b1;
`ifdef PSEQ_ABORT_EN
        abort_req = abort;
`else
        abort_req = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        verts_d  = verts_q;
        vcnt_d   = vcnt_q;
        closed_d = closed_q;
        idx_d    = idx_q;
`ifdef PSEQ_ABORT_EN
        aborted_d = aborted_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (vert_count < TWO || vert_count > MAXV) begin
                        state_d = S_ERR;
                    end else begin
                        state_d  = S_DRAW;
                        verts_d  = coords;
                        vcnt_d   = vert_count;
                        closed_d = closed;
                        idx_d    = '0;
                    end
                end
            end
            S_ERR:  state_d = S_IDLE;
            S_DRAW: begin
                // abort wins over a simultaneous draw_done
                if (abort_req) begin
                    state_d = S_DONE;
`ifdef PSEQ_ABORT_EN
                    aborted_d = 1'b1;
`endif
                end else if (line.draw_done) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GAP;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (abort_req) begin
                    state_d = S_DONE;
`ifdef PSEQ_ABORT_EN
                    aborted_d = 1'b1;
`endif
                end else begin
                    state_d = S_DRAW;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef PSEQ_ABORT_EN
                aborted_d = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode only registered state, so they are glitch-free and
    // independent of same-cycle inputs.
    always_comb begin
        line.draw_en = (state_q == S_DRAW);
        line.x0 = '0;
        line.y0 = '0;
        line.x1 = '0;
        line.y1 = '0;
        if (state_q == S_DRAW) begin
            line.x0 = verts_q[idx_q][COORD_W-1:0];
            line.y0 = verts_q[idx_q][2*COORD_W-1:COORD_W];
            line.x1 = verts_q[nxt_idx][COORD_W-1:0];
            line.y1 = verts_q[nxt_idx][2*COORD_W-1:COORD_W];
        end
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
        err  = (state_q == S_ERR);
`ifdef PSEQ_ABORT_EN
        aborted = (state_q == S_DONE) && aborted_q;
`endif
    end
endmodule

// File: tb/tb_polygon_edge_sequencer.sv
module tb_polygon_edge_sequencer;
    localparam int CW = 8;
    localparam int MV = 8;
    localparam int VW = $clog2(MV + 1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [VW-1:0]         vert_count;
    logic                  closed;
    logic [2*CW*MV-1:0]    coords_in;
    logic                  busy, done, err;
`ifdef PSEQ_ABORT_EN
    logic                  abort, aborted;
`endif

    polygon_edge_sequencer_if #(.COORD_W(CW)) line_bus ();

    polygon_edge_sequencer #(.COORD_W(CW), .MAX_VERTS(MV)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .vert_count (vert_count),
        .closed     (closed),
        .coords     (coords_in),
`ifdef PSEQ_ABORT_EN
        .abort      (abort),
        .aborted    (aborted),
`endif
        .busy       (busy),
        .done       (done),
        .err        (err),
        .line       (line_bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [4*CW-1:0] sb_q[$];
    logic [4*CW-1:0] obs_edge;
    assign obs_edge = {line_bus.x0, line_bus.y0, line_bus.x1, line_bus.y1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vert(input int i, input int x, input int y);
        coords_in[2*CW*i +: CW]    = CW'(x);
        coords_in[2*CW*i+CW +: CW] = CW'(y);
    endtask

    function automatic logic [2*CW-1:0] vxy(input int i);
        return {coords_in[2*CW*i +: CW], coords_in[2*CW*i+CW +: CW]};
    endfunction

    function automatic int edge_cnt(input int vc, input bit cl);
        if (!cl) return vc - 1;
        return (vc >= 3) ? vc : 1;
    endfunction

    task automatic push_edges(input int vc, input bit cl);
        for (int k = 0; k < edge_cnt(vc, cl); k++)
            sb_q.push_back({vxy(k), vxy((k + 1) % vc)});
    endtask

    task automatic scramble();
        for (int w = 0; w < 2*CW*MV/32; w++) coords_in[32*w +: 32] = $urandom;
    endtask

    task automatic pop_chk(input string tag);
        logic [4*CW-1:0] exp;
        chk({tag, "_sb_avail"}, 64'(sb_q.size() != 0), 64'd1);
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        chk({tag, "_draw_en"}, 64'(line_bus.draw_en), 64'd1);
        chk({tag, "_edge"}, 64'(obs_edge), 64'(exp));
    endtask

    // Full command: expected edges go on the scoreboard at start, are popped as
    // the DUT presents each edge, and the line engine answers after dly cycles.
    task automatic run_cmd(input int vc, input bit cl, input int dly);
        int e;
        logic [4*CW-1:0] held;
        e = edge_cnt(vc, cl);
        push_edges(vc, cl);
        vert_count = VW'(vc);
        closed = cl;
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble();   // decode stage moves on; outputs must keep latched data
        for (int k = 0; k < e; k++) begin
            pop_chk("edge");
            held = obs_edge;
            for (int d = 0; d < dly; d++) begin
                start = (d == 0);   // start is ignored while drawing
                tick();
                chk("hold_edge", 64'(obs_edge), 64'(held));
                chk("hold_en", 64'(line_bus.draw_en), 64'd1);
            end
            start = 1'b0;
            line_bus.draw_done = 1'b1;
            tick();
            line_bus.draw_done = 1'b0;
            if (k == e - 1) begin
                chk("done_pulse", 64'(done), 64'd1);
                chk("done_en", 64'(line_bus.draw_en), 64'd0);
                chk("done_coords", 64'(obs_edge), 64'd0);
                chk("done_busy", 64'(busy), 64'd1);
`ifdef PSEQ_ABORT_EN
                chk("done_not_aborted", 64'(aborted), 64'd0);
`endif
                tick();
                chk("idle_busy", 64'(busy), 64'd0);
                chk("idle_done", 64'(done), 64'd0);
            end else begin
                chk("gap_en", 64'(line_bus.draw_en), 64'd0);
                chk("gap_coords", 64'(obs_edge), 64'd0);
                chk("gap_done", 64'(done), 64'd0);
                tick();
            end
        end
    endtask

    task automatic err_cmd(input int vc);
        vert_count = VW'(vc);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_pulse", 64'(err), 64'd1);
        chk("err_busy", 64'(busy), 64'd1);
        chk("err_en", 64'(line_bus.draw_en), 64'd0);
        tick();
        chk("err_clear", 64'(err), 64'd0);
        chk("err_idle", 64'(busy), 64'd0);
        chk("err_no_en", 64'(line_bus.draw_en), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; vert_count = '0; closed = 1'b0; coords_in = '0;
        line_bus.draw_done = 1'b0;
`ifdef PSEQ_ABORT_EN
        abort = 1'b0;
`endif
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_en", 64'(line_bus.draw_en), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_coords", 64'(obs_edge), 64'd0);
        rst = 1'b0;
        tick();

        // draw_done outside DRAW is ignored
        line_bus.draw_done = 1'b1;
        tick();
        line_bus.draw_done = 1'b0;
        chk("idle_dd_ignored", 64'(busy), 64'd0);

        // open segment
        set_vert(0, 10, 20); set_vert(1, 30, 40);
        run_cmd(2, 1'b0, 5);

        // closed triangle
        set_vert(0, 0, 0); set_vert(1, 50, 0); set_vert(2, 25, 40);
        run_cmd(3, 1'b1, 2);

        // closed with two vertices draws one edge
        set_vert(0, 7, 9); set_vert(1, 200, 100);
        run_cmd(2, 1'b1, 1);

        // closed octagon, wrap edge v7->v0; coords scrambled during drawing
        for (int i = 0; i < MV; i++) set_vert(i, 16*i + 3, 255 - 11*i);
        run_cmd(MV, 1'b1, 1);

        // open 8-vertex polyline with immediate draw_done
        for (int i = 0; i < MV; i++) set_vert(i, $urandom_range(0, 255), $urandom_range(0, 255));
        run_cmd(MV, 1'b0, 0);

        // rejected counts
        err_cmd(1);
        err_cmd(MV + 1);
        err_cmd(0);

        // reset during the second edge of a 4-vertex polyline
        for (int i = 0; i < 4; i++) set_vert(i, 40 + i, 60 - i);
        push_edges(4, 1'b0);
        vert_count = VW'(4); closed = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        pop_chk("rst_e0");
        line_bus.draw_done = 1'b1;
        tick();
        line_bus.draw_done = 1'b0;
        chk("rst_gap_en", 64'(line_bus.draw_en), 64'd0);
        tick();
        pop_chk("rst_e1");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_en", 64'(line_bus.draw_en), 64'd0);
        chk("midrst_coords", 64'(obs_edge), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        sb_q.delete();   // dropped edges
        for (int i = 0; i < 4; i++) set_vert(i, 90 + 3*i, 20 + 5*i);
        run_cmd(4, 1'b0, 1);

`ifdef PSEQ_ABORT_EN
        // abort together with draw_done on edge 1 of a pentagon
        for (int i = 0; i < 5; i++) set_vert(i, 10*i + 1, 100 - 7*i);
        push_edges(5, 1'b1);
        vert_count = VW'(5); closed = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        pop_chk("ab_e0");
        line_bus.draw_done = 1'b1;
        tick();
        line_bus.draw_done = 1'b0;
        tick();
        pop_chk("ab_e1");
        abort = 1'b1; line_bus.draw_done = 1'b1;
        tick();
        abort = 1'b0; line_bus.draw_done = 1'b0;
        chk("ab_done", 64'(done), 64'd1);
        chk("ab_aborted", 64'(aborted), 64'd1);
        chk("ab_en", 64'(line_bus.draw_en), 64'd0);
        tick();
        chk("ab_idle", 64'(busy), 64'd0);
        chk("ab_aborted_clr", 64'(aborted), 64'd0);
        tick();
        chk("ab_no_more_edges", 64'(line_bus.draw_en), 64'd0);
        sb_q.delete();
`endif

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/polygon_edge_sequencer.md
Name: polygon_edge_sequencer

Overview:
Parametrised edge sequencer that feeds the Bresenham line-draw engine one edge at a time. It replaces the fixed 2/3-vertex line/triangle controller. It supports up to MAX_VERTS vertices, configurable coordinate width, and open-polyline or closed-polygon mode. Vertex data is captured at start so the decode stage may change its outputs during drawing. The block sits between the instruction decode and the line rasteriser.

Parameters:
COORD_W, 8, bits per x or y coordinate
MAX_VERTS, 8, maximum vertices per command (>=2)
VCNT_W, $clog2(MAX_VERTS+1), width of vertex-count input

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  command strobe; sampled only in IDLE
vert_count  in  VCNT_W  number of valid vertices in coords
closed  in  1  1 = closed polygon, 0 = open polyline; sampled with start
coords  in  2*COORD_W*MAX_VERTS  vertex i: x at [2*COORD_W*i +: COORD_W], y at [2*COORD_W*i+COORD_W +: COORD_W]
draw_done  in  1  line engine finished current edge
x0, y0, x1, y1  out  COORD_W each  current edge endpoints
draw_en  out  1  request line engine to draw current edge
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse, command complete
err  out  1  one-cycle pulse, command rejected

Behaviour:
- Reset (sync, rst=1 at clk edge): state IDLE. All outputs 0. Vertex buffer and counters cleared.
- Reset mid-operation: same as above. The pending edge is dropped and no done pulse is produced.
- Edge count E:
  - open: E = vert_count-1
  - closed with vert_count>=3: E = vert_count
  - closed with vert_count==2: E = 1 (no duplicate reverse edge)
- Edge k runs from vertex k to vertex (k+1) mod vert_count.
- States:
  - IDLE: on start=1:
    - If vert_count<2 or vert_count>MAX_VERTS → ERR.
    - Otherwise latch coords, closed and vert_count into registers, set edge index=0, go to DRAW.
    - start in any other state is ignored.
  - ERR: err=1 for one cycle, then IDLE. No draw_en.
  - DRAW:
    - draw_en=1. x0/y0/x1/y1 show edge k from the latched buffer and are stable for the whole state.
    - On draw_done=1: if k==E-1 → DONE, else k++ and → GAP.
  - GAP: draw_en=0, coords=0, for exactly one cycle, then DRAW (next edge).
  - DONE: done=1 for one cycle, coords=0, then IDLE.
- Outputs are registered state decode. x0..y1 are 0 outside DRAW.
- Latency: start at cycle t gives draw_en=1 at t+1. Each edge's draw_done at cycle c is followed by draw_en=0 at c+1. The next edge's draw_en=1 comes at c+2.
- draw_done in IDLE, GAP, ERR or DONE is ignored.
- Wrap-around: the closing edge uses vertex vert_count-1 → vertex 0, never an unlatched slot.
- Edge index width is $clog2(MAX_VERTS). It never exceeds E-1.

Optional Feature:
Macro PSEQ_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in DRAW or GAP: the next state is DONE, draw_en drops the next cycle, and done pulses.
  - Adds output aborted (1 bit), high together with that done pulse only.
  - abort has priority over a simultaneous draw_done.
  - abort is ignored in IDLE, ERR and DONE.
- Not defined: neither port exists and the sequence always runs to completion.

Test Plan:
- Open, vert_count=2, v0=(10,20), v1=(30,40), start → one DRAW with (10,20)->(30,40); draw_done 5 cycles later; done pulses the cycle after draw_done; busy low the cycle after that.
- Closed triangle (0,0),(50,0),(25,40) → three edges in order (0,0)-(50,0), (50,0)-(25,40), (25,40)-(0,0); draw_en low exactly one cycle between edges; single done pulse.
- Closed, vert_count=MAX_VERTS=8 → 8 edges, last edge (v7)-(v0); change coords input during drawing → outputs still show the latched values.
- vert_count=1, then vert_count=9 → err pulses one cycle each; draw_en never asserted; busy high for one cycle.
- rst asserted during edge 2 of a 4-vertex polyline → all outputs 0 next cycle, no done; new start accepted the cycle after rst deasserts.
- With PSEQ_ABORT_EN: abort and draw_done together during edge 1 of a pentagon → done=1, aborted=1 next cycle; no further edges drawn.
